// File: rtl/calc_pkg.sv
// Key codes, key map and scanner state shared by the keypad scanner and the operation block.
// Pure declarations: no clock, no latency, no flow control.
package calc_pkg;

    localparam logic [3:0] ADD      = 4'hC;
    localparam logic [3:0] SUB      = 4'hB;
    localparam logic [3:0] IGUAL    = 4'hD;
    localparam logic [3:0] RECOVERY = 4'hE;
    localparam logic [3:0] SAVE     = 4'hF;
    localparam logic [3:0] RESERVED = 4'hA;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } scan_state_t;

    // idx = row*4 + col
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = ADD;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = SUB;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = IGUAL;
            4'd12:   code = RECOVERY;
            4'd13:   code = 4'd0;
            4'd14:   code = SAVE;
            default: code = RESERVED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous active-low keypad rows; 2-cycle latency.
// Free-running, no flow control; resets to all rows inactive.
module row_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan, debounce and key-code mapping; one ready pulse per debounced press,
// registered one cycle after the end-of-scan evaluation. No backpressure: consumer must take every pulse.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] tecla,
    output logic       ready,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [3:0]    row_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [15:0]   hits;
    logic [15:0]   scan_vec;
    logic          col_end;
    logic          scan_end;
    logic [4:0]    n_hits;
    logic [3:0]    hit_idx;
    logic          is_none;
    logic          is_key;

    scan_state_t   state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    tecla_n;
    logic          ready_n;
    logic          key_held_n;
    logic          accept;

    row_sync u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_s)
    );

    assign col_end  = (dwell == DWELL_LAST);
    assign scan_end = col_end && (col == 2'd3);

    // Current column's synced rows merged into the hit map of the scan in progress.
    always_comb begin
        scan_vec = hits;
        for (int r = 0; r < 4; r++) begin
            scan_vec[r*4 + int'(col)] = ~row_s[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell <= '0;
            col   <= 2'd0;
            col_n <= 4'b1110;
            hits  <= '0;
        end else if (col_end) begin
            dwell <= '0;
            col   <= col + 2'd1;
            col_n <= ~(4'b0001 << (col + 2'd1));
            hits  <= scan_vec;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    always_comb begin
        n_hits  = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_vec[i]) begin
                n_hits  = n_hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign is_none = (n_hits == 5'd0);
    assign is_key  = (n_hits == 5'd1);
    assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cand     <= '0;
            cnt      <= '0;
            tecla    <= 4'h0;
            ready    <= 1'b0;
            key_held <= 1'b0;
        end else begin
            state    <= state_n;
            cand     <= cand_n;
            cnt      <= cnt_n;
            tecla    <= tecla_n;
            ready    <= ready_n;
            key_held <= key_held_n;
        end
    end

    always_comb begin
        state_n    = state;
        cand_n     = cand;
        cnt_n      = cnt;
        tecla_n    = tecla;
        ready_n    = 1'b0;
        key_held_n = key_held;
        accept     = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (is_key) begin
                        cand_n = hit_idx;
                        cnt_n  = CNT_ONE;
                        if (CNT_ONE >= CNT_DONE) begin
                            accept = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (is_key && hit_idx == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            accept = 1'b1;
                        end
                    end else if (is_key) begin
                        cand_n = hit_idx;
                        cnt_n  = CNT_ONE;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        if (CNT_ONE >= CNT_DONE) begin
                            state_n    = IDLE;
                            cnt_n      = '0;
                            key_held_n = 1'b0;
                        end else begin
                            state_n = RELEASE;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (is_none) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_n    = IDLE;
                            cnt_n      = '0;
                            key_held_n = 1'b0;
                        end
                    end else begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end
                end
            endcase
        end
        if (accept) begin
            state_n    = PRESSED;
            tecla_n    = key_map(cand_n);
            ready_n    = 1'b1;
            key_held_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed scenarios against a keypad matrix model; expected key codes are queued at press time
// and matched against each ready pulse by a monitor.
module tb_keypad_scanner;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  tecla;
    logic        ready;
    logic        key_held;

    logic [15:0] keys;            // keys[row*4+col] = pressed
    logic [3:0]  exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          pulses      = 0;
    int          t           = 0;
    int          base        = 0;
    logic        prev_ready  = 1'b0;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_n    (row_n),
        .col_n    (col_n),
        .tecla    (tecla),
        .ready    (ready),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Lands on the first cycle of column 0 and makes that t = 0.
    task automatic align();
        logic [3:0] prev;
        bit         found;
        int         n;
        found = 1'b0;
        n     = 0;
        prev  = col_n;
        while (!found && n < 64) begin
            @(negedge clk);
            n++;
            found = (prev == 4'b0111) && (col_n == 4'b1110);
            prev  = col_n;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $error("FAIL align: observed col_n %b, expected scan wrap within 64 cycles", col_n);
        end
        t = 0;
    endtask

    // Scoreboard side: every pulse must match the oldest queued key code.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                pulses++;
                if (prev_ready) chk("ready_back_to_back", 32'(prev_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_pulse: observed tecla %0h, expected no pulse", tecla);
                end else begin
                    e = exp_q.pop_front();
                    chk("tecla", 32'(tecla), 32'(e));
                end
            end
            prev_ready = (ready === 1'b1);
        end
    end

    initial begin
        keys  = 16'h0010;         // row 1 held through reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_col_n", 32'(col_n), 32'hE);
        chk("rst_tecla", 32'(tecla), 32'h0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_key_held", 32'(key_held), 32'd0);
        chk("rst_no_pulse", 32'(pulses), 32'd0);
        keys  = '0;
        reset = 1'b0;

        // Single press (1,2) held 10 scans
        align();
        keys = 16'h0040;
        exp_q.push_back(4'd6);
        base = pulses;
        chk("col0", 32'(col_n), 32'hE);
        goto(4);   chk("col1", 32'(col_n), 32'hD);
        goto(8);   chk("col2", 32'(col_n), 32'hB);
        goto(12);  chk("col3", 32'(col_n), 32'h7);
        goto(46);  chk("single_early", 32'(pulses - base), 32'd0);
        goto(50);  chk("single_pulse", 32'(pulses - base), 32'd1);
        chk("single_held", 32'(key_held), 32'd1);
        goto(160); chk("single_once", 32'(pulses - base), 32'd1);
        chk("single_still_held", 32'(key_held), 32'd1);
        keys = '0;
        goto(206); chk("release_not_yet", 32'(key_held), 32'd1);
        goto(210); chk("release_done", 32'(key_held), 32'd0);
        chk("single_q_empty", 32'(exp_q.size()), 32'd0);

        // Bounce: 2 scans on, 1 off, 3 on (key 0,1)
        align();
        keys = 16'h0002;
        base = pulses;
        goto(32);  keys = '0;
        goto(48);  keys = 16'h0002; exp_q.push_back(4'd2);
        goto(94);  chk("bounce_early", 32'(pulses - base), 32'd0);
        goto(98);  chk("bounce_pulse", 32'(pulses - base), 32'd1);
        keys = '0;
        goto(178); chk("bounce_released", 32'(key_held), 32'd0);
        chk("bounce_q_empty", 32'(exp_q.size()), 32'd0);

        // Multi-key (0,0)+(1,1), then (1,1) released
        align();
        keys = 16'h0021;
        base = pulses;
        goto(64);  chk("multi_no_pulse", 32'(pulses - base), 32'd0);
        chk("multi_not_held", 32'(key_held), 32'd0);
        keys = 16'h0001;
        exp_q.push_back(4'd1);
        goto(110); chk("multi_early", 32'(pulses - base), 32'd0);
        goto(114); chk("multi_pulse", 32'(pulses - base), 32'd1);
        keys = '0;
        goto(200); chk("multi_released", 32'(key_held), 32'd0);
        chk("multi_q_empty", 32'(exp_q.size()), 32'd0);

        // Release debounce on (3,2) = SAVE
        align();
        keys = 16'h4000;
        exp_q.push_back(SAVE);
        base = pulses;
        goto(50);  chk("rel_first_pulse", 32'(pulses - base), 32'd1);
        goto(64);  keys = '0;
        goto(96);  keys = 16'h4000;
        goto(128); chk("rel_short_no_pulse", 32'(pulses - base), 32'd1);
        chk("rel_short_held", 32'(key_held), 32'd1);
        keys = '0;
        goto(174); chk("rel_held_late", 32'(key_held), 32'd1);
        goto(178); chk("rel_dropped", 32'(key_held), 32'd0);
        goto(192); keys = 16'h4000; exp_q.push_back(SAVE);
        goto(238); chk("rel_second_early", 32'(pulses - base), 32'd1);
        goto(242); chk("rel_second_pulse", 32'(pulses - base), 32'd2);
        keys = '0;
        goto(300); chk("rel_final_release", 32'(key_held), 32'd0);
        chk("rel_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset during 2nd debounce scan of (2,3) = IGUAL
        align();
        keys = 16'h0800;
        base = pulses;
        goto(20);  reset = 1'b1; keys = '0;
        goto(22);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        chk("mid_rst_col_n", 32'(col_n), 32'hE);
        chk("mid_rst_held", 32'(key_held), 32'd0);
        reset = 1'b0;
        goto(70);  chk("mid_rst_no_pulse", 32'(pulses - base), 32'd0);
        align();
        keys = 16'h0800;
        exp_q.push_back(IGUAL);
        base = pulses;
        goto(46);  chk("mid_rst_fresh_early", 32'(pulses - base), 32'd0);
        goto(50);  chk("mid_rst_fresh_pulse", 32'(pulses - base), 32'd1);
        keys = '0;
        goto(110); chk("mid_rst_released", 32'(key_held), 32'd0);
        chk("mid_rst_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
